dizy_sbox_layer_ctrl: RTL and testbench

Sequencer that applies the 2-share masked 5-bit DIZY S-box to every word of a masked state through one shared, pipelined `sbox_masked` instance. It serializes NWORDS words into the S-box and feeds each issue with 20 fresh random bits from the PRNG through a valid/ready handshake. Results are written back in place, in share form, as they leave the S-box pipeline. It sits between the round-function state register and the single S-box instance of the masked core.

---
 rtl/dizy_sbox_layer_ctrl.sv | 152 +++++++++++++++
 tb/tb_dizy_sbox_layer_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dizy_sbox_layer_ctrl.sv
// Sequencer that streams every 5-bit word of a 2-share masked state through one shared,
// pipelined masked S-box and writes each result back in place as it leaves the pipeline.
module dizy_sbox_layer_ctrl #(
   parameter int unsigned NWORDS   = 7,
   parameter int unsigned SBOX_LAT = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   input  logic [5*NWORDS-1:0] state_in_a,
   input  logic [5*NWORDS-1:0] state_in_b,
   output logic [5*NWORDS-1:0] state_out_a,
   output logic [5*NWORDS-1:0] state_out_b,
   input  logic [19:0]         rnd,
   input  logic                rnd_valid,
   output logic                rnd_ready,
   output logic [4:0]          sb_in_a,
   output logic [4:0]          sb_in_b,
   output logic [19:0]         sb_z,
   input  logic [4:0]          sb_out_a,
   input  logic [4:0]          sb_out_b
);

   localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int unsigned SW = 5 * NWORDS;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e              st_q, st_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [SW-1:0]       sh_a_q, sh_a_d, sh_b_q, sh_b_d;
   logic [SBOX_LAT-1:0] vld_q, vld_d;
   logic [IW-1:0]       tag_q [SBOX_LAT];
   logic [IW-1:0]       tag_d [SBOX_LAT];

   logic       load;
   logic       fire;
   logic       pending;
   logic [4:0] word_a, word_b;

   assign fire        = rnd_valid & rnd_ready;
   assign state_out_a = sh_a_q;
   assign state_out_b = sh_b_q;

   always_comb begin
      st_d      = st_q;
      idx_d     = idx_q;
      busy      = (st_q != StIdle);
      done      = 1'b0;
      rnd_ready = 1'b0;
      load      = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (start) begin
               load  = 1'b1;
               idx_d = '0;
               st_d  = StIssue;
            end
         end
         StIssue: begin
            rnd_ready = 1'b1;
            if (rnd_valid) begin
               if (idx_q == IW'(NWORDS - 1)) begin
                  st_d = StDrain;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         StDrain: begin
            // Entries below the tail are the ones still in flight after this cycle.
            if (!pending) begin
               st_d = StDone;
            end
         end
         StDone: begin
            done = 1'b1;
            st_d = StIdle;
         end
         default: st_d = StIdle;
      endcase
   end

   always_comb begin
      pending = 1'b0;
      for (int unsigned k = 0; k + 1 < SBOX_LAT; k++) begin
         pending = pending | vld_q[k];
      end
   end

   // Each share is selected through its own mux; the two are never combined.
   always_comb begin
      word_a = '0;
      word_b = '0;
      for (int unsigned w = 0; w < NWORDS; w++) begin
         if (idx_q == IW'(w)) begin
            word_a = sh_a_q[5*w +: 5];
            word_b = sh_b_q[5*w +: 5];
         end
      end
      sb_in_a = fire ? word_a : '0;
      sb_in_b = fire ? word_b : '0;
      sb_z    = fire ? rnd : '0;
   end

   always_comb begin
      vld_d[0] = fire;
      tag_d[0] = idx_q;
      for (int unsigned k = 1; k < SBOX_LAT; k++) begin
         vld_d[k] = vld_q[k-1];
         tag_d[k] = tag_q[k-1];
      end
   end

   always_comb begin
      sh_a_d = load ? state_in_a : sh_a_q;
      sh_b_d = load ? state_in_b : sh_b_q;
      if (vld_q[SBOX_LAT-1]) begin
         for (int unsigned w = 0; w < NWORDS; w++) begin
            if (tag_q[SBOX_LAT-1] == IW'(w)) begin
               sh_a_d[5*w +: 5] = sb_out_a;
               sh_b_d[5*w +: 5] = sb_out_b;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= StIdle;
         idx_q  <= '0;
         sh_a_q <= '0;
         sh_b_q <= '0;
         vld_q  <= '0;
         for (int unsigned k = 0; k < SBOX_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         st_q   <= st_d;
         idx_q  <= idx_d;
         sh_a_q <= sh_a_d;
         sh_b_q <= sh_b_d;
         vld_q  <= vld_d;
         for (int unsigned k = 0; k < SBOX_LAT; k++) begin
            tag_q[k] <= tag_d[k];
         end
      end
   end

endmodule

// File: tb/tb_dizy_sbox_layer_ctrl.sv
// Scoreboard bench: a driver issues masked layer passes and queues the expected outcome, a
// monitor checks control, share hygiene and the final recombined state on every done pulse.
module tb_dizy_sbox_layer_ctrl;

   localparam int NW  = 7;
   localparam int LAT = 6;
   localparam int SW  = 5 * NW;

   // Stand-in 5-bit permutation for the external S-box with S(0)=0 and S(1)=4; the
   // controller never looks inside the S-box, so any such table exercises it fully.
   localparam logic [4:0] SBOX [0:31] = '{
      5'd0,  5'd4,  5'd17, 5'd29, 5'd9,  5'd26, 5'd3,  5'd22,
      5'd12, 5'd31, 5'd7,  5'd18, 5'd24, 5'd1,  5'd14, 5'd27,
      5'd20, 5'd11, 5'd30, 5'd5,  5'd16, 5'd25, 5'd2,  5'd13,
      5'd6,  5'd19, 5'd28, 5'd10, 5'd23, 5'd8,  5'd21, 5'd15};

   logic          clk = 1'b0;
   logic          rst, start, busy, done;
   logic [SW-1:0] state_in_a, state_in_b, state_out_a, state_out_b;
   logic [19:0]   rnd, sb_z;
   logic          rnd_valid, rnd_ready;
   logic [4:0]    sb_in_a, sb_in_b, sb_out_a, sb_out_b;

   dizy_sbox_layer_ctrl #(.NWORDS(NW), .SBOX_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .state_in_a(state_in_a), .state_in_b(state_in_b),
      .state_out_a(state_out_a), .state_out_b(state_out_b),
      .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .sb_in_a(sb_in_a), .sb_in_b(sb_in_b), .sb_z(sb_z),
      .sb_out_a(sb_out_a), .sb_out_b(sb_out_b));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Masked S-box model: capture mid-cycle, emerge LAT cycles later remasked with sb_z.
   logic [4:0] cap_a, cap_b;
   logic [4:0] pa [LAT];
   logic [4:0] pb [LAT];
   always @(negedge clk) begin
      cap_a <= SBOX[sb_in_a ^ sb_in_b] ^ sb_z[4:0];
      cap_b <= sb_z[4:0];
   end
   always @(posedge clk) begin
      for (int k = LAT - 1; k > 0; k--) begin
         pa[k] <= pa[k-1];
         pb[k] <= pb[k-1];
      end
      pa[0] <= cap_a;
      pb[0] <= cap_b;
   end
   assign sb_out_a = pa[LAT-1];
   assign sb_out_b = pb[LAT-1];

   typedef struct {
      logic [SW-1:0] res;
      int            done_abs;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic logic [SW-1:0] rand_vec();
      return SW'({$urandom(), $urandom()});
   endfunction

   // Driver-owned expectations read by the monitor.
   logic          exp_busy = 1'b0;
   logic          exp_ready = 1'b0;
   logic          in_pass = 1'b0;
   int            t0 = 0;
   logic [SW-1:0] cur_x = '0;

   // Monitor-owned state.
   int            fires = 0;
   int            mon_rel;
   int            wb_cnt [NW];
   int            wb_max;
   logic [SW-1:0] prev_a, prev_b;
   exp_t          e_mon;

   always @(negedge clk) begin
      mon_rel = cyc - t0;
      if (in_pass && mon_rel == 0) fires = 0;
      if (in_pass && mon_rel == 1) for (int w = 0; w < NW; w++) wb_cnt[w] = 0;
      check("busy", 64'(busy), 64'(exp_busy));
      check("rnd_ready", 64'(rnd_ready), 64'(exp_ready));
      if (rnd_ready && rnd_valid) begin
         check("sb_z_on_fire", 64'(sb_z), 64'(rnd));
         if (fires < NW) check("issued_word", 64'(sb_in_a ^ sb_in_b), 64'(cur_x[5*fires +: 5]));
         else check("fire_overrun", 64'(fires), 64'(NW - 1));
         fires++;
      end else begin
         check("bubble_zero", 64'({sb_in_a, sb_in_b, sb_z}), 64'(0));
      end
      if (in_pass && mon_rel >= 2) begin
         for (int w = 0; w < NW; w++) begin
            if (state_out_a[5*w +: 5] !== prev_a[5*w +: 5] ||
                state_out_b[5*w +: 5] !== prev_b[5*w +: 5]) wb_cnt[w]++;
         end
      end
      prev_a = state_out_a;
      prev_b = state_out_b;
      if (done) begin
         check("done_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e_mon = exp_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(e_mon.done_abs));
            check("result", 64'(state_out_a ^ state_out_b), 64'(e_mon.res));
            check("fire_count", 64'(fires), 64'(NW));
            wb_max = 0;
            for (int w = 0; w < NW; w++) if (wb_cnt[w] > wb_max) wb_max = wb_cnt[w];
            check("single_writeback", 64'(wb_max <= 1), 64'(1));
         end
      end
   end

   // mode 0: rnd_valid always 1; mode 1: 1,0,1,0...; mode 2: random gaps.
   task automatic do_pass(input logic [SW-1:0] x, input int mode, input int abort_at,
                          input bit poke);
      bit            pv[$];
      bit            v;
      int            nf, last, done_rel, end_c;
      logic [SW-1:0] res;
      exp_t          e;
      nf   = 0;
      last = 0;
      while (nf < NW) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (pv.size() % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0) || (pv.size() > 60);
         endcase
         pv.push_back(v);
         if (v) begin
            nf++;
            last = pv.size();
         end
      end
      done_rel = last + LAT + 1;
      for (int w = 0; w < NW; w++) res[5*w +: 5] = SBOX[x[5*w +: 5]];

      @(posedge clk); #1;
      t0         = cyc;
      cur_x      = x;
      in_pass    = 1'b1;
      state_in_a = rand_vec();
      state_in_b = state_in_a ^ x;
      start      = 1'b1;
      rnd        = 20'($urandom());
      rnd_valid  = 1'($urandom_range(0, 1));
      exp_busy   = 1'b0;
      exp_ready  = 1'b0;
      if (abort_at < 0) begin
         e.res      = res;
         e.done_abs = t0 + done_rel;
         exp_q.push_back(e);
      end
      end_c = (abort_at >= 0) ? abort_at + 20 : (poke ? done_rel + 2 : done_rel);
      for (int c = 1; c <= end_c; c++) begin
         @(posedge clk); #1;
         start     = 1'b0;
         rst       = 1'b0;
         rnd       = 20'($urandom());
         rnd_valid = (c <= last) ? pv[c-1] : 1'($urandom_range(0, 1));
         exp_busy  = (c <= done_rel);
         exp_ready = (c <= last);
         if (abort_at >= 0 && c > abort_at) begin
            exp_busy  = 1'b0;
            exp_ready = 1'b0;
         end
         if (poke && (c == 3 || c == done_rel)) begin
            start      = 1'b1;
            state_in_a = rand_vec();
            state_in_b = rand_vec();
         end
         if (c == abort_at) rst = 1'b1;
         if (abort_at >= 0 && c == abort_at + 1) begin
            @(negedge clk);
            check("abort_state_a", 64'(state_out_a), 64'(0));
            check("abort_state_b", 64'(state_out_b), 64'(0));
            check("abort_busy", 64'(busy), 64'(0));
            check("abort_ready", 64'(rnd_ready), 64'(0));
         end
      end
      @(negedge clk); #1;
      if (abort_at < 0) check("done_seen", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      in_pass = 1'b0;
   endtask

   logic [SW-1:0] ones;

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      rnd_valid  = 1'b1;
      rnd        = 20'hABCDE;
      state_in_a = '1;
      state_in_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state_a", 64'(state_out_a), 64'(0));
      check("reset_state_b", 64'(state_out_b), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_sb", 64'({sb_in_a, sb_in_b, sb_z}), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);

      for (int w = 0; w < NW; w++) ones[5*w +: 5] = 5'd1;
      do_pass(ones, 0, -1, 1'b0);           // basic pass
      do_pass('0, 0, -1, 1'b0);             // zero state
      do_pass(ones, 1, -1, 1'b0);           // randomness stalls
      do_pass(rand_vec(), 0, 5, 1'b0);      // reset mid-pass
      do_pass(rand_vec(), 0, -1, 1'b0);     // restart after abort
      do_pass(rand_vec(), 0, -1, 1'b1);     // start while busy / in DONE
      for (int i = 0; i < 6; i++) do_pass(rand_vec(), 2, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
